hex_display_scanner: RTL and testbench

//  Time-multiplexes a 32-bit word across DIGITS common-anode 7-seg digits.

---
 rtl/hex_display_scanner_if.sv | 10 +
 rtl/hex_display_scanner.sv | 137 +++++++++++++
 tb/tb_hex_display_scanner.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scanner_if.sv
// Write-side handshake bundle for hex_display_scanner: a 32-bit word offered with
// valid/ready. The scanner is the slave; the word source is the master.
interface hex_display_scanner_if;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexes a double-buffered 32-bit word across DIGITS common-anode 7-seg digits.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses anodes above the top non-zero nibble).
module hex_display_scanner #(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_display_scanner_if.slave  wr,
    output logic [31:0]           nibble_data,
    output logic [DIGITS-1:0]     digit_an,
    output logic [2:0]            digit_idx,
    output logic                  frame_done
);

    localparam int CW = $clog2(PRESCALE);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t        state_reg,        state_next;
    logic [CW-1:0] cnt_reg,          cnt_next;
    logic [2:0]    idx_reg,          idx_next;
    logic [31:0]   active_reg,       active_next;
    logic [31:0]   pending_reg,      pending_next;
    logic          pending_full_reg, pending_full_next;
    logic [3:0]    nibble_reg,       nibble_next;
    logic          frame_done_reg,   frame_done_next;

    logic          accept;
    logic          commit;
    logic [2:0]    idx_wrap;
    logic [31:0]   src_word;
    logic [DIGITS-1:0] show;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= BLANK;
            cnt_reg          <= '0;
            idx_reg          <= '0;
            active_reg       <= '0;
            pending_reg      <= '0;
            pending_full_reg <= 1'b0;
            nibble_reg       <= '0;
            frame_done_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            idx_reg          <= idx_next;
            active_reg       <= active_next;
            pending_reg      <= pending_next;
            pending_full_reg <= pending_full_next;
            nibble_reg       <= nibble_next;
            frame_done_reg   <= frame_done_next;
        end
    end

    assign accept   = wr.wr_valid & ~pending_full_reg;
    assign idx_wrap = (idx_reg == 3'(DIGITS - 1)) ? 3'd0 : idx_reg + 3'd1;
    // Commit only uses the pending flag as it stood before this edge, so a word
    // accepted on the boundary cycle itself waits for the following frame.
    assign commit   = (state_reg == DRIVE) && (cnt_reg == CW'(PRESCALE - 1))
                      && (idx_reg == 3'(DIGITS - 1)) && pending_full_reg;
    assign src_word = commit ? pending_reg : active_reg;

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        idx_next          = idx_reg;
        active_next       = active_reg;
        pending_next      = pending_reg;
        pending_full_next = pending_full_reg;
        nibble_next       = nibble_reg;
        frame_done_next   = 1'b0;

        if (accept) begin
            pending_next      = wr.wr_data;
            pending_full_next = 1'b1;
        end

        case (state_reg)
            BLANK: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(BLANK_CYCLES - 1)) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_reg == CW'(PRESCALE - 1)) begin
                    state_next  = BLANK;
                    cnt_next    = '0;
                    idx_next    = idx_wrap;
                    nibble_next = src_word[{idx_wrap, 2'b00} +: 4];
                    if (commit) begin
                        active_next       = pending_reg;
                        pending_full_next = 1'b0;
                        frame_done_next   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] nz;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
        assign nz[gi] = |active_reg[4*gi +: 4];
        if (gi == 0) begin : g_first
            assign show[gi] = 1'b1;
        end else begin : g_upper
            assign show[gi] = |nz[DIGITS-1:gi];
        end
    end
`else
    assign show = '1;
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
        assign digit_an[gi] = ~((state_reg == DRIVE) && (idx_reg == 3'(gi)) && show[gi]);
    end

    assign wr.wr_ready  = ~pending_full_reg;
    assign nibble_data  = {28'b0, nibble_reg};
    assign digit_idx    = idx_reg;
    assign frame_done   = frame_done_reg;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with DIGITS=4, PRESCALE=4, BLANK_CYCLES=1.
// Cycle c is the negedge c clocks after reset release; slot s spans cycles 4s..4s+3.
module tb_hex_display_scanner;

    logic        clk;
    logic        rst_n;
    logic [31:0] nibble_data;
    logic [3:0]  digit_an;
    logic [2:0]  digit_idx;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    hex_display_scanner_if bus ();

    hex_display_scanner #(
        .DIGITS       (4),
        .PRESCALE     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (bus.slave),
        .nibble_data (nibble_data),
        .digit_an    (digit_an),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_an"},    32'(digit_an),    32'h0000_000F);
        check_eq({tag, "_nib"},   nibble_data,      32'h0);
        check_eq({tag, "_rdy"},   32'(bus.wr_ready), 32'h1);
        check_eq({tag, "_idx"},   32'(digit_idx),   32'h0);
        check_eq({tag, "_fdone"}, 32'(frame_done),  32'h0);
    endtask

    // Drive a one-cycle write at the current negedge; it is accepted on the next posedge.
    task automatic pulse_write(input logic [31:0] data);
        bus.wr_valid = 1'b1;
        bus.wr_data  = data;
        @(negedge clk);
        cyc++;
        bus.wr_valid = 1'b0;
    endtask

    logic [3:0] an_pat [6];

    initial begin
        an_pat[0] = 4'b1111; an_pat[1] = 4'b1110; an_pat[2] = 4'b1110;
        an_pat[3] = 4'b1110; an_pat[4] = 4'b1111; an_pat[5] = 4'b1101;

        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 32'h0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        #1;
        check_eq("pat_c0", 32'(digit_an), 32'(an_pat[0]));
        for (int i = 1; i < 6; i++) begin
            step_to(i);
            check_eq($sformatf("pat_c%0d", i), 32'(digit_an), 32'(an_pat[i]));
        end

        // Single write of h4321, committed at the first boundary.
        pulse_write(32'h0000_4321);
        check_eq("wr1_rdy_low", 32'(bus.wr_ready), 32'h0);
        step_to(15);
        check_eq("wr1_pre_nib", nibble_data, 32'h0);
        check_eq("wr1_pre_fd",  32'(frame_done), 32'h0);
        step_to(16);
        check_eq("wr1_fdone", 32'(frame_done), 32'h1);
        check_eq("wr1_nib0",  nibble_data, 32'h1);
        check_eq("wr1_rdy",   32'(bus.wr_ready), 32'h1);
        step_to(17);
        check_eq("wr1_fd_pulse", 32'(frame_done), 32'h0);
        for (int d = 1; d < 4; d++) begin
            step_to(16 + 4*d);
            check_eq($sformatf("wr1_nib%0d", d), nibble_data, 32'(d + 1));
            check_eq($sformatf("wr1_idx%0d", d), 32'(digit_idx), 32'(d));
        end
        step_to(29);
        check_eq("wr1_an3", 32'(digit_an), 32'h7);
        step_to(32);
        check_eq("wr1_period_nib", nibble_data, 32'h1);
        check_eq("wr1_period_idx", 32'(digit_idx), 32'h0);
        check_eq("wr1_no_pend_fd", 32'(frame_done), 32'h0);

        // Back-to-back: h1234 accepted, h5678 held until the pending slot frees.
        step_to(33);
        pulse_write(32'h0000_1234);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h0000_5678;
        step_to(40);
        check_eq("b2b_old_nib2", nibble_data, 32'h3);
        check_eq("b2b_rdy_low", 32'(bus.wr_ready), 32'h0);
        step_to(48);
        check_eq("b2b_fd1",  32'(frame_done), 32'h1);
        check_eq("b2b_nib0", nibble_data, 32'h4);
        check_eq("b2b_rdy",  32'(bus.wr_ready), 32'h1);
        step_to(49);
        bus.wr_valid = 1'b0;
        check_eq("b2b_rdy2_low", 32'(bus.wr_ready), 32'h0);
        step_to(52);
        check_eq("b2b_nib1", nibble_data, 32'h3);
        step_to(60);
        check_eq("b2b_nib3", nibble_data, 32'h1);
        step_to(64);
        check_eq("b2b_fd2",   32'(frame_done), 32'h1);
        check_eq("b2b_nib0b", nibble_data, 32'h8);
        step_to(68);
        check_eq("b2b_nib1b", nibble_data, 32'h7);
        step_to(80);
        check_eq("b2b_idle_fd", 32'(frame_done), 32'h0);

        // Write accepted on the boundary cycle itself.
        step_to(95);
        pulse_write(32'h0000_ABCD);
        check_eq("bnd_fd_none", 32'(frame_done), 32'h0);
        check_eq("bnd_nib_old", nibble_data, 32'h8);
        check_eq("bnd_rdy_low", 32'(bus.wr_ready), 32'h0);
        step_to(100);
        check_eq("bnd_nib1_old", nibble_data, 32'h7);
        step_to(112);
        check_eq("bnd_fd",  32'(frame_done), 32'h1);
        check_eq("bnd_nib", nibble_data, 32'hD);

        // Reset mid-DRIVE with a pending word.
        step_to(113);
        pulse_write(32'h0000_0FED);
        check_eq("mrst_rdy_low", 32'(bus.wr_ready), 32'h0);
        step_to(115);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        step_to(4);
        check_eq("mrst_nib1", nibble_data, 32'h0);
        step_to(16);
        check_eq("mrst_fd",   32'(frame_done), 32'h0);
        check_eq("mrst_nib0", nibble_data, 32'h0);

        // Leading-zero handling: h50 then 0.
        step_to(17);
        pulse_write(32'h0000_0050);
        step_to(32);
        check_eq("lz_fd", 32'(frame_done), 32'h1);
        step_to(33);
        check_eq("lz50_an0", 32'(digit_an), 32'hE);
        step_to(37);
        check_eq("lz50_an1",  32'(digit_an), 32'hD);
        check_eq("lz50_nib1", nibble_data, 32'h5);
        step_to(41);
`ifdef LEADING_ZERO_BLANK_EN
        check_eq("lz50_an2", 32'(digit_an), 32'hF);
        step_to(45);
        check_eq("lz50_an3", 32'(digit_an), 32'hF);
`else
        check_eq("lz50_an2", 32'(digit_an), 32'hB);
        step_to(45);
        check_eq("lz50_an3", 32'(digit_an), 32'h7);
`endif
        step_to(49);
        pulse_write(32'h0000_0000);
        step_to(64);
        check_eq("lz0_fd", 32'(frame_done), 32'h1);
        step_to(65);
        check_eq("lz0_an0", 32'(digit_an), 32'hE);
        step_to(69);
`ifdef LEADING_ZERO_BLANK_EN
        check_eq("lz0_an1", 32'(digit_an), 32'hF);
        step_to(77);
        check_eq("lz0_an3", 32'(digit_an), 32'hF);
`else
        check_eq("lz0_an1", 32'(digit_an), 32'hD);
        step_to(77);
        check_eq("lz0_an3", 32'(digit_an), 32'h7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
